// File: rtl/ofm_writeback_packer.sv
// rtl/ofm_writeback_packer.sv - packs 16x8-bit OFM vectors into 32-bit channel-last BRAM writes
// Optional OFM_WB_PERF_CNT_EN adds stall_cnt/drop_cnt performance counters.
module ofm_writeback_packer #(
   parameter int ADDR_W = 32,
   parameter int FIFO_D = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        OFM_W,
   input  logic [7:0]        OFM_C,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [127:0]      ofm_bus,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              busy,
   output logic              done,
   output logic              overflow
`ifdef OFM_WB_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [15:0]       drop_cnt
`endif
);

   typedef enum logic {S_IDLE, S_RUN} state_t;
   state_t state, state_nxt;

   logic [127:0]      mem [0:1];
   logic              wr_ptr, rd_ptr, fin;
   logic [1:0]        count, k;
   logic [15:0]       pix, pix_last;
   logic [3:0]        tile, tiles, tile_last;
   logic [7:0]        w_lat;
   logic [ADDR_W-1:0] base_lat, addr_calc;
   logic [127:0]      head;
   logic              push, pop, drop, have, degenerate, is_last;

   assign busy       = (state == S_RUN);
   // fin marks the cycle the final word is on the bus: still RUN, but nothing more is accepted
   assign in_ready   = busy && (32'(count) < FIFO_D) && !fin;
   assign push       = in_valid && in_ready;
   assign drop       = in_valid && busy && !in_ready;
   assign have       = busy && !fin && ((count != 2'd0) || push);
   assign head       = (count == 2'd0) ? ofm_bus : mem[rd_ptr];
   assign pop        = have && (k == 2'd3);
   assign pix_last   = 16'(w_lat) * 16'(w_lat) - 16'd1;
   assign tile_last  = tiles - 4'd1;
   assign is_last    = pop && (pix == pix_last) && (tile == tile_last);
   assign degenerate = (OFM_W == 8'd0) || (OFM_C < 8'd16);
   assign addr_calc  = base_lat + ADDR_W'(pix) * ADDR_W'({tiles, 2'b00})
                     + ADDR_W'({tile, 2'b00}) + ADDR_W'(k);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (start)
         state_nxt = degenerate ? S_IDLE : S_RUN;
      else if (state == S_RUN && fin)
         state_nxt = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0; rd_ptr <= 1'b0; count <= '0; k <= '0;
         pix <= '0; tile <= '0; tiles <= '0; w_lat <= '0; base_lat <= '0;
         fin <= 1'b0; wr_en <= 1'b0; wr_addr <= '0; wr_data <= '0;
         done <= 1'b0; overflow <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         if (start) begin
            w_lat <= OFM_W; tiles <= OFM_C[7:4]; base_lat <= base_addr;
            wr_ptr <= 1'b0; rd_ptr <= 1'b0; count <= '0; k <= '0;
            pix <= '0; tile <= '0; fin <= 1'b0; overflow <= 1'b0;
            done <= degenerate;
         end else begin
            if (busy && fin) begin
               done <= 1'b1;
               fin  <= 1'b0;
            end
            if (drop) overflow <= 1'b1;
            if (push) begin
               mem[wr_ptr] <= ofm_bus;
               wr_ptr      <= ~wr_ptr;
            end
            // an empty FIFO forwards ofm_bus straight to the serialiser for one-cycle latency
            if (have) begin
               wr_en   <= 1'b1;
               wr_addr <= addr_calc;
               wr_data <= head[{k, 5'b0} +: 32];
               k       <= k + 2'd1;
               if (k == 2'd3) begin
                  rd_ptr <= ~rd_ptr;
                  if (pix == pix_last) begin
                     pix  <= '0;
                     tile <= tile + 4'd1;
                  end else begin
                     pix <= pix + 16'd1;
                  end
                  if (is_last) fin <= 1'b1;
               end
            end
            count <= count + {1'b0, push} - {1'b0, pop};
         end
      end
   end

`ifdef OFM_WB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n || start) begin
         stall_cnt <= '0;
         drop_cnt  <= '0;
      end else begin
         if (busy && count == 2'd0) stall_cnt <= stall_cnt + 32'd1;
         if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ofm_writeback_packer.sv
// tb/tb_ofm_writeback_packer.sv - directed self-checking bench for ofm_writeback_packer
module tb_ofm_writeback_packer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, start, in_valid, in_ready, wr_en, busy, done, overflow;
   logic [7:0]   ofm_w, ofm_c;
   logic [31:0]  base_addr, wr_addr, wr_data;
   logic [127:0] ofm_bus;
`ifdef OFM_WB_PERF_CNT_EN
   logic [31:0]  stall_cnt;
   logic [15:0]  drop_cnt;
`endif

   ofm_writeback_packer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .OFM_W(ofm_w), .OFM_C(ofm_c),
      .base_addr(base_addr), .in_valid(in_valid), .in_ready(in_ready), .ofm_bus(ofm_bus),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
      .overflow(overflow)
`ifdef OFM_WB_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
`endif
   );

   int checks = 0, failures = 0;
   int cyc = 0, nw = 0, ndone = 0, done_cyc = 0, t0;
   logic [31:0] wa [64];
   logic [31:0] wd [64];
   int          wcyc [64];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (wr_en && nw < 64) begin
         wa[nw] = wr_addr; wd[nw] = wr_data; wcyc[nw] = cyc;
         nw++;
      end
      if (done) begin
         ndone++;
         done_cyc = cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] mkvec(input int p);
      logic [127:0] v;
      for (int i = 0; i < 16; i++) v[8*i +: 8] = 8'(i + 16*p);
      return v;
   endfunction

   function automatic logic [31:0] expw(input int p, input int k);
      logic [31:0] w;
      for (int n = 0; n < 4; n++) w[8*n +: 8] = 8'(4*k + n + 16*p);
      return w;
   endfunction

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_log();
      nw = 0; ndone = 0;
   endtask

   task automatic send(input int p);
      in_valid = 1'b1; ofm_bus = mkvec(p);
      sample();
      in_valid = 1'b0;
   endtask

   task automatic do_start(input logic [7:0] w, input logic [7:0] c, input logic [31:0] b);
      ofm_w = w; ofm_c = c; base_addr = b; start = 1'b1;
      sample();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      for (int i = 0; i < budget && ndone == 0; i++) sample();
      check({tag, "_done_seen"}, 32'(ndone != 0), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; ofm_bus = '0;
      ofm_w = '0; ofm_c = '0; base_addr = '0;
      sample(); sample();
      check("rst_wr_en", 32'(wr_en), 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_in_ready", 32'(in_ready), 0);
      rst_n = 1'b1;
      sample();

      // T1: 2x2 pixels, one tile, vectors paced one per four cycles
      clear_log();
      do_start(8'd2, 8'd16, 32'h100);
      check("t1_busy", 32'(busy), 1);
      check("t1_in_ready", 32'(in_ready), 1);
      t0 = cyc;
      for (int p = 0; p < 4; p++) begin
         send(p);
         sample(); sample(); sample();
      end
      wait_done("t1", 40);
      check("t1_nwrites", 32'(nw), 16);
      for (int j = 0; j < 16 && j < nw; j++) begin
         check($sformatf("t1_addr%0d", j), wa[j], 32'h100 + 32'(j));
         check($sformatf("t1_data%0d", j), wd[j], expw(j / 4, j % 4));
      end
      check("t1_first_data", wd[0], 32'h03020100);
      check("t1_latency", 32'(wcyc[0]), 32'(t0 + 1));
      check("t1_no_bubble", 32'(wcyc[15] - wcyc[0]), 15);
      check("t1_done_after_last", 32'(done_cyc), 32'(wcyc[15] + 1));
      sample(); sample();
      check("t1_done_once", 32'(ndone), 1);
      check("t1_idle", 32'(busy), 0);
      check("t1_no_ovf", 32'(overflow), 0);

      // T2: single pixel, two tiles
      clear_log();
      do_start(8'd1, 8'd32, 32'h0);
      send(7); send(8);
      wait_done("t2", 30);
      check("t2_nwrites", 32'(nw), 8);
      for (int j = 0; j < 8 && j < nw; j++)
         check($sformatf("t2_addr%0d", j), wa[j], 32'(j));
      check("t2_data3", wd[3], expw(7, 3));
      check("t2_data4", wd[4], expw(8, 0));
      sample(); sample();
      check("t2_done_once", 32'(ndone), 1);

      // T3: three back-to-back vectors, third one is dropped
      clear_log();
      do_start(8'd1, 8'd32, 32'h40);
      send(1); send(2); send(3);
      check("t3_overflow", 32'(overflow), 1);
      wait_done("t3", 30);
      check("t3_nwrites", 32'(nw), 8);
      check("t3_no_bubble", 32'(wcyc[7] - wcyc[0]), 7);
      check("t3_data4", wd[4], expw(2, 0));
      check("t3_data7", wd[7], expw(2, 3));
      check("t3_addr7", wa[7], 32'h47);
      check("t3_ovf_sticky", 32'(overflow), 1);
`ifdef OFM_WB_PERF_CNT_EN
      check("t3_drop_cnt", 32'(drop_cnt), 1);
`endif

      // T4: restart after five writes
      clear_log();
      do_start(8'd2, 8'd16, 32'h200);
      send(4); send(5); send(6);
      check("t4_overflow_set", 32'(overflow), 1);
      for (int i = 0; i < 20 && nw < 5; i++) sample();
      check("t4_five_writes", 32'(nw), 5);
      base_addr = 32'h300; start = 1'b1;
      sample();
      start = 1'b0;
      check("t4_wr_en_low", 32'(wr_en), 0);
      check("t4_ovf_clear", 32'(overflow), 0);
      check("t4_busy", 32'(busy), 1);
      check("t4_no_more_writes", 32'(nw), 5);
      clear_log();
      send(9);
      check("t4_restart_write", 32'(nw), 1);
      check("t4_restart_addr", wa[0], 32'h300);
      check("t4_restart_data", wd[0], expw(9, 0));
      check("t4_wr_en_high", 32'(wr_en), 1);

      // T5: one-cycle reset while writing
      rst_n = 1'b0;
      sample();
      rst_n = 1'b1;
      check("t5_wr_en", 32'(wr_en), 0);
      check("t5_wr_addr", wr_addr, 0);
      check("t5_wr_data", wr_data, 0);
      check("t5_busy", 32'(busy), 0);
      check("t5_overflow", 32'(overflow), 0);
      clear_log();
      send(10);
      sample(); sample(); sample(); sample();
      check("t5_ignored_writes", 32'(nw), 0);
      check("t5_ignored_ovf", 32'(overflow), 0);
      check("t5_ignored_busy", 32'(busy), 0);

      // T6: degenerate configurations
      clear_log();
      do_start(8'd0, 8'd16, 32'h500);
      check("t6_done", 32'(done), 1);
      check("t6_busy", 32'(busy), 0);
      sample(); sample(); sample();
      check("t6_nwrites", 32'(nw), 0);
      check("t6_done_once", 32'(ndone), 1);
      clear_log();
      do_start(8'd4, 8'd8, 32'h0);
      check("t6c_done", 32'(done), 1);
      sample(); sample();
      check("t6c_nwrites", 32'(nw), 0);
`ifdef OFM_WB_PERF_CNT_EN
      check("t6_stall_cnt", stall_cnt, 0);
      check("t6_drop_cnt", 32'(drop_cnt), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
